score_timer: RTL and testbench

- Game-session score and countdown block, directly downstream of the score slow-clock divider.
- Samples the divider's slow_clk level in the fast clk domain and turns each rising edge into a one-cycle tick.
- Uses ticks to run the per-game countdown, and tallies mole hits into a saturating BCD score.
- Feeds the seven-segment display mux and the game-over logic.

---
 rtl/score_timer_pkg.sv | 13 +
 rtl/score_timer_bcd_digit.sv | 27 ++
 rtl/score_timer.sv | 134 +++++++++++++
 tb/tb_score_timer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_timer_pkg.sv
// Shared types and constants for the score_timer game-session block.
package score_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/score_timer_bcd_digit.sv
// One decimal score digit; chained through carry_in/carry_out, frozen while hold is high.
module bcd_digit
    import score_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             carry_in,
    input  logic             hold,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    assign carry_out = carry_in && (digit == BCD_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (inc && carry_in && !hold) begin
            digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/score_timer.sv
// Game countdown driven by synchronised slow_clk ticks, plus a saturating BCD hit score.
// Optional high-score tracking is built when SCORE_TIMER_HIGH_SCORE_EN is defined.
module score_timer
    import score_timer_pkg::*;
#(
    parameter int SCORE_DIGITS  = 3,
    parameter int GAME_SECONDS  = 60,
    parameter int TICKS_PER_SEC = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          slow_clk,
    input  logic                          start,
    input  logic                          hit,
    output logic [BCD_W*SCORE_DIGITS-1:0] score_bcd,
    output logic [6:0]                    time_left,
    output logic                          running,
    output logic                          game_over,
`ifdef SCORE_TIMER_HIGH_SCORE_EN
    output logic [BCD_W*SCORE_DIGITS-1:0] high_score,
    output logic                          new_high,
`endif
    output logic [1:0]                    dbg_state
);

    localparam int               SUB_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [6:0]       TIME_LOAD = 7'(GAME_SECONDS);

    state_t           state, next_state;
    logic             sync1, sync2, sync3;
    logic             tick;
    logic [SUB_W-1:0] sub_cnt;
    logic             begin_game;
    logic             sec_wrap;
    logic             last_dec;
    logic             score_inc;
    logic [SCORE_DIGITS:0] carry;

    // slow_clk is unrelated to clk: two flops to resolve metastability, a third for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= slow_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick       = sync2 && !sync3;
    assign begin_game = start && (state != RUN);
    assign sec_wrap   = (state == RUN) && tick && (sub_cnt == SUB_LAST);
    assign last_dec   = sec_wrap && (time_left == 7'd1);
    assign score_inc  = hit && (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = RUN;
            RUN:     if (last_dec) next_state = OVER;
            OVER:    if (start)    next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt   <= '0;
            time_left <= '0;
        end else if (begin_game) begin
            sub_cnt   <= '0;
            time_left <= TIME_LOAD;
        end else if ((state == RUN) && tick) begin
            if (sec_wrap) begin
                sub_cnt   <= '0;
                time_left <= time_left - 7'd1;
            end else begin
                sub_cnt   <= sub_cnt + 1'b1;
            end
        end
    end

    assign running   = (state == RUN);
    assign game_over = (state == OVER);
    assign dbg_state = state;

    // The carry out of the top digit is high exactly when every digit is 9, so it doubles as hold.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clear     (begin_game),
            .inc       (score_inc),
            .carry_in  (carry[g]),
            .hold      (carry[SCORE_DIGITS]),
            .digit     (score_bcd[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

`ifdef SCORE_TIMER_HIGH_SCORE_EN
    logic end_q;

    // Compare one cycle after the game ends so a hit on the final tick is part of the score.
    // Valid BCD orders the same as binary, so a plain magnitude compare suffices.
    assign new_high = end_q && (score_bcd > high_score);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            end_q      <= 1'b0;
            high_score <= '0;
        end else begin
            end_q <= last_dec;
            if (new_high) begin
                high_score <= score_bcd;
            end
        end
    end
`endif

endmodule

// File: tb/tb_score_timer.sv
// Directed bench for score_timer: two instances (60 s default and 2 s game) share stimulus;
// expected snapshots are queued by the stimulus and compared by a negedge monitor.
module tb_score_timer;

    localparam int W = 23;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic slow_clk = 1'b0;
    logic start = 1'b0;
    logic hit = 1'b0;

    logic [11:0] a_score, b_score;
    logic [6:0]  a_time, b_time;
    logic        a_running, b_running, a_over, b_over;
    logic [1:0]  a_state, b_state;
`ifdef SCORE_TIMER_HIGH_SCORE_EN
    logic [11:0] a_high, b_high;
    logic        a_new_high, b_new_high;
    logic [12:0] hs_q[$];
    string       hs_nm_q[$];
`endif

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    string        nm_a_q[$];
    string        nm_b_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    score_timer u_a (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .hit(hit),
        .score_bcd(a_score), .time_left(a_time), .running(a_running), .game_over(a_over),
`ifdef SCORE_TIMER_HIGH_SCORE_EN
        .high_score(a_high), .new_high(a_new_high),
`endif
        .dbg_state(a_state)
    );

    score_timer #(.GAME_SECONDS(2)) u_b (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .hit(hit),
        .score_bcd(b_score), .time_left(b_time), .running(b_running), .game_over(b_over),
`ifdef SCORE_TIMER_HIGH_SCORE_EN
        .high_score(b_high), .new_high(b_new_high),
`endif
        .dbg_state(b_state)
    );

    function automatic logic [W-1:0] pack(logic [1:0] st, logic [6:0] tl, logic [11:0] sc);
        return {st, (st == 2'd1), (st == 2'd2), tl, sc};
    endfunction

    task automatic exp_a(string nm, logic [1:0] st, logic [6:0] tl, logic [11:0] sc);
        exp_a_q.push_back(pack(st, tl, sc));
        nm_a_q.push_back(nm);
    endtask

    task automatic exp_b(string nm, logic [1:0] st, logic [6:0] tl, logic [11:0] sc);
        exp_b_q.push_back(pack(st, tl, sc));
        nm_b_q.push_back(nm);
    endtask

    task automatic compare(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d run=%0b over=%0b time=%0d score=%h, expected state=%0d run=%0b over=%0b time=%0d score=%h",
                     nm, act[22:21], act[20], act[19], act[18:12], act[11:0],
                     exp[22:21], exp[20], exp[19], exp[18:12], exp[11:0]);
        end
    endtask

    // Monitor: drains whatever expectations the stimulus queued during this cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        string        n;
        while (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            n = nm_a_q.pop_front();
            compare({"a_", n}, {a_state, a_running, a_over, a_time, a_score}, e);
        end
        while (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            n = nm_b_q.pop_front();
            compare({"b_", n}, {b_state, b_running, b_over, b_time, b_score}, e);
        end
`ifdef SCORE_TIMER_HIGH_SCORE_EN
        while (hs_q.size() > 0) begin
            logic [12:0] h;
            h = hs_q.pop_front();
            n = hs_nm_q.pop_front();
            checks++;
            if ({b_new_high, b_high} !== h) begin
                errors++;
                $display("FAIL %s: got new_high=%0b high_score=%h, expected new_high=%0b high_score=%h",
                         n, b_new_high, b_high, h[12], h[11:0]);
            end
        end
`endif
    end

    task automatic wait_clk(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_slow();
        slow_clk = 1'b1;
        wait_clk(4);
        slow_clk = 1'b0;
        wait_clk(4);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        wait_clk(1);
        hit = 1'b0;
        wait_clk(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_clk(1);
        start = 1'b0;
    endtask

`ifdef SCORE_TIMER_HIGH_SCORE_EN
    task automatic exp_hs(string nm, logic nh, logic [11:0] hs);
        hs_q.push_back({nh, hs});
        hs_nm_q.push_back(nm);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: inputs wiggle, nothing may move.
        for (int i = 0; i < 6; i++) begin
            slow_clk = ~slow_clk;
            hit = ~hit;
            wait_clk(1);
        end
        slow_clk = 1'b0;
        hit = 1'b0;
        wait_clk(1);
        exp_a("reset_hold", 2'd0, 7'd0, 12'h000);
        exp_b("reset_hold", 2'd0, 7'd0, 12'h000);
        reset = 1'b1;
        wait_clk(3);
        exp_a("reset_release", 2'd0, 7'd0, 12'h000);
        exp_b("reset_release", 2'd0, 7'd0, 12'h000);

        pulse_start();
        exp_a("start_run", 2'd1, 7'd60, 12'h000);
        exp_b("start_run", 2'd1, 7'd2, 12'h000);

        // Five edges: decrement lands on the third clk edge after the fifth rise.
        repeat (4) pulse_slow();
        exp_a("four_ticks", 2'd1, 7'd60, 12'h000);
        slow_clk = 1'b1;
        wait_clk(2);
        exp_a("tick5_pre", 2'd1, 7'd60, 12'h000);
        wait_clk(1);
        exp_a("tick5_dec", 2'd1, 7'd59, 12'h000);
        exp_b("tick5_dec", 2'd1, 7'd1, 12'h000);
        slow_clk = 1'b0;
        wait_clk(4);

        repeat (12) pulse_hit();
        exp_a("hits12", 2'd1, 7'd59, 12'h012);
        exp_b("hits12", 2'd1, 7'd1, 12'h012);

        pulse_start();
        wait_clk(1);
        exp_a("start_in_run", 2'd1, 7'd59, 12'h012);
        exp_b("start_in_run", 2'd1, 7'd1, 12'h012);

        // Tenth edge ends the 2 s game; a hit on that same cycle still counts.
        repeat (4) pulse_slow();
        slow_clk = 1'b1;
        wait_clk(2);
        hit = 1'b1;
        wait_clk(1);
        hit = 1'b0;
        exp_b("final_tick_hit", 2'd2, 7'd0, 12'h013);
        exp_a("tick10", 2'd1, 7'd58, 12'h013);
        slow_clk = 1'b0;
        wait_clk(4);

        repeat (3) pulse_hit();
        exp_b("hits_over", 2'd2, 7'd0, 12'h013);
        exp_a("hits_run", 2'd1, 7'd58, 12'h016);
        repeat (2) pulse_slow();
        exp_b("ticks_over", 2'd2, 7'd0, 12'h013);
        exp_a("ticks_partial", 2'd1, 7'd58, 12'h016);

        repeat (983) pulse_hit();
        exp_a("sat_reach", 2'd1, 7'd58, 12'h999);
        repeat (17) pulse_hit();
        exp_a("sat_hold", 2'd1, 7'd58, 12'h999);
        exp_b("over_hold", 2'd2, 7'd0, 12'h013);

        start = 1'b1;
        hit = 1'b1;
        wait_clk(1);
        start = 1'b0;
        hit = 1'b0;
        exp_b("start_hit_over", 2'd1, 7'd2, 12'h000);
        exp_a("start_hit_run", 2'd1, 7'd58, 12'h999);

        // Async reset must act before the next clock edge.
        wait_clk(1);
        reset = 1'b0;
        #1;
        exp_a("async_reset", 2'd0, 7'd0, 12'h000);
        exp_b("async_reset", 2'd0, 7'd0, 12'h000);
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2);

`ifdef SCORE_TIMER_HIGH_SCORE_EN
        pulse_start();
        repeat (7) pulse_hit();
        repeat (9) pulse_slow();
        slow_clk = 1'b1;
        wait_clk(3);
        exp_b("g1_over", 2'd2, 7'd0, 12'h007);
        exp_hs("g1_new_high", 1'b1, 12'h000);
        wait_clk(1);
        exp_hs("g1_loaded", 1'b0, 12'h007);
        slow_clk = 1'b0;
        wait_clk(4);

        pulse_start();
        exp_hs("g2_start_keep", 1'b0, 12'h007);
        repeat (4) pulse_hit();
        repeat (9) pulse_slow();
        slow_clk = 1'b1;
        wait_clk(3);
        exp_b("g2_over", 2'd2, 7'd0, 12'h004);
        exp_hs("g2_no_new", 1'b0, 12'h007);
        wait_clk(1);
        exp_hs("g2_keep", 1'b0, 12'h007);
        slow_clk = 1'b0;
        wait_clk(4);

        pulse_start();
        repeat (2) pulse_hit();
        reset = 1'b0;
        #1;
        exp_hs("reset_hs", 1'b0, 12'h000);
        exp_b("reset_mid_game", 2'd0, 7'd0, 12'h000);
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2);
`endif

        wait_clk(2);
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations never compared, required 0",
                     exp_a_q.size(), exp_b_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
